// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the slide-switch debouncer.
package sw_debounce_pkg;

  localparam int unsigned CNT_MAX_50MHZ_1MS = 50000;

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_H,
    S_HIGH,
    S_WAIT_L
  } db_state_t;

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounce channel: two-flop synchroniser, stability counter and a
// four-state FSM driving registered level/rise/fall/toggle outputs.
module sw_debounce_chan
  import sw_debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_50MHZ_1MS,
  parameter int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic CLK,
  input  logic NRST,
  input  logic sw_in,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_toggle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             ff1_q;
  logic             sync_q;
  db_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             toggle_q;

  // NOTE: non-blocking assignments make ff1_q and sync_q two real flops;
  // blocking here would collapse the synchroniser into a single stage.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      ff1_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      ff1_q  <= sw_in;
      sync_q <= ff1_q;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        S_LOW: begin
          if (sync_q) begin
            state_q <= S_WAIT_H;
            cnt_q   <= CNT_ONE;
          end
        end
        S_WAIT_H: begin
          if (!sync_q) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= S_HIGH;
            cnt_q    <= '0;
            level_q  <= 1'b1;
            rise_q   <= 1'b1;
            toggle_q <= ~toggle_q;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sync_q) begin
            state_q <= S_WAIT_L;
            cnt_q   <= CNT_ONE;
          end
        end
        S_WAIT_L: begin
          if (sync_q) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= S_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sw_level  = level_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign sw_toggle = toggle_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces NB_SW independent slide switches; one channel instance per switch.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned NB_SW   = 2,
  parameter int unsigned CNT_MAX = CNT_MAX_50MHZ_1MS,
  parameter int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [NB_SW-1:0] sw_in,
  output logic [NB_SW-1:0] sw_level,
  output logic [NB_SW-1:0] sw_rise,
  output logic [NB_SW-1:0] sw_fall,
  output logic [NB_SW-1:0] sw_toggle
);

  for (genvar i = 0; i < NB_SW; i++) begin : g_chan
    sw_debounce_chan #(
      .CNT_MAX(CNT_MAX),
      .CNT_W  (CNT_W)
    ) u_chan (
      .CLK      (CLK),
      .NRST     (NRST),
      .sw_in    (sw_in[i]),
      .sw_level (sw_level[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i]),
      .sw_toggle(sw_toggle[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with NB_SW=2, CNT_MAX=4 (level moves 6 edges
// after the first edge that samples a new stable input).
module tb_sw_debounce;

  logic       CLK;
  logic       NRST;
  logic [1:0] sw_in;
  logic [1:0] sw_level;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;
  logic [1:0] sw_toggle;

  int test_run  = 0;
  int test_fail = 0;

  sw_debounce #(
    .NB_SW  (2),
    .CNT_MAX(4)
  ) dut (
    .CLK      (CLK),
    .NRST     (NRST),
    .sw_in    (sw_in),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_toggle(sw_toggle)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Inputs are driven and outputs sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    NRST  = 1'b0;
    sw_in = 2'b00;
    step();
    step();
    NRST = 1'b1;
  endtask

  task automatic watch(input int n, input int ch, output int n_rise, output int n_fall,
                       output int first_rise, output int first_fall, output int both);
    n_rise = 0; n_fall = 0; first_rise = -1; first_fall = -1; both = 0;
    for (int s = 1; s <= n; s++) begin
      step();
      if (sw_rise[ch]) begin
        n_rise++;
        if (first_rise < 0) first_rise = s;
      end
      if (sw_fall[ch]) begin
        n_fall++;
        if (first_fall < 0) first_fall = s;
      end
      if ((sw_rise & sw_fall) != 2'b00) both++;
    end
  endtask

  task automatic test_reset();
    logic [1:0] exp_lvl, exp_rise;
    NRST  = 1'b0;
    sw_in = 2'b11;
    for (int s = 0; s < 3; s++) begin
      step();
      test_run++;
      if ({sw_level, sw_rise, sw_fall, sw_toggle} !== 8'h00) begin
        test_fail++;
        $display("FAIL reset_hold: got %b expected 00000000",
                 {sw_level, sw_rise, sw_fall, sw_toggle});
      end
    end
    NRST = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step();
      exp_lvl  = (s >= 7) ? 2'b11 : 2'b00;
      exp_rise = (s == 7) ? 2'b11 : 2'b00;
      test_run++;
      if ({sw_level, sw_rise} !== {exp_lvl, exp_rise}) begin
        test_fail++;
        $display("FAIL reset_release step %0d: level/rise got %b expected %b",
                 s, {sw_level, sw_rise}, {exp_lvl, exp_rise});
      end
    end
    test_run++;
    if (sw_toggle !== 2'b11) begin
      test_fail++;
      $display("FAIL reset_release_toggle: got %b expected 11", sw_toggle);
    end
  endtask

  task automatic test_rise_ch0();
    logic [1:0] exp_lvl, exp_rise;
    apply_reset();
    sw_in = 2'b01;
    for (int s = 1; s <= 8; s++) begin
      step();
      exp_lvl  = (s >= 7) ? 2'b01 : 2'b00;
      exp_rise = (s == 7) ? 2'b01 : 2'b00;
      test_run++;
      if ({sw_level, sw_rise, sw_fall} !== {exp_lvl, exp_rise, 2'b00}) begin
        test_fail++;
        $display("FAIL rise_ch0 step %0d: level/rise/fall got %b expected %b",
                 s, {sw_level, sw_rise, sw_fall}, {exp_lvl, exp_rise, 2'b00});
      end
    end
    test_run++;
    if (sw_toggle !== 2'b01) begin
      test_fail++;
      $display("FAIL rise_ch0_toggle: got %b expected 01", sw_toggle);
    end
  endtask

  task automatic test_glitch();
    int nr, nf, fr, ff, bo;
    apply_reset();
    sw_in = 2'b01;
    step(); step(); step();
    sw_in = 2'b00;
    watch(12, 0, nr, nf, fr, ff, bo);
    test_run++;
    if (nr != 0 || sw_level !== 2'b00 || sw_toggle !== 2'b00) begin
      test_fail++;
      $display("FAIL glitch_reject: rises %0d level %b toggle %b expected 0 00 00",
               nr, sw_level, sw_toggle);
    end
    // A full-latency rise afterwards shows the channel went back to S_LOW.
    sw_in = 2'b01;
    watch(8, 0, nr, nf, fr, ff, bo);
    test_run++;
    if (fr != 7 || nr != 1) begin
      test_fail++;
      $display("FAIL glitch_recover: first rise step %0d count %0d expected 7 1", fr, nr);
    end
  endtask

  task automatic test_bounce();
    int nr, nf, fr, ff, bo;
    int bounce_rise = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      sw_in = {(i % 2 == 0), 1'b0};
      step();
      if (sw_rise[1]) bounce_rise++;
    end
    sw_in = 2'b10;
    watch(12, 1, nr, nf, fr, ff, bo);
    test_run++;
    if (bounce_rise != 0 || nr != 1 || fr != 7) begin
      test_fail++;
      $display("FAIL bounce: rises during/after %0d/%0d at step %0d expected 0/1 at 7",
               bounce_rise, nr, fr);
    end
    test_run++;
    if (sw_level !== 2'b10 || sw_toggle !== 2'b10) begin
      test_fail++;
      $display("FAIL bounce_level: level %b toggle %b expected 10 10", sw_level, sw_toggle);
    end
  endtask

  task automatic test_press_release();
    int nr, nf, fr, ff, bo;
    logic exp_tog;
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      exp_tog = (c == 0);
      sw_in = 2'b01;
      watch(8, 0, nr, nf, fr, ff, bo);
      test_run++;
      if (nr != 1 || fr != 7 || nf != 0 || sw_toggle[0] !== exp_tog || bo != 0) begin
        test_fail++;
        $display("FAIL press %0d: rise %0d@%0d fall %0d toggle %b both %0d expected 1@7 0 %b 0",
                 c, nr, fr, nf, sw_toggle[0], bo, exp_tog);
      end
      sw_in = 2'b00;
      watch(8, 0, nr, nf, fr, ff, bo);
      test_run++;
      if (nf != 1 || ff != 7 || nr != 0 || sw_toggle[0] !== exp_tog || sw_level !== 2'b00 || bo != 0) begin
        test_fail++;
        $display("FAIL release %0d: fall %0d@%0d rise %0d toggle %b level %b both %0d expected 1@7 0 %b 00 0",
                 c, nf, ff, nr, sw_toggle[0], sw_level, bo, exp_tog);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [1:0] exp_lvl, exp_rise;
    apply_reset();
    sw_in = 2'b01;
    for (int s = 0; s < 7; s++) step();
    test_run++;
    if (sw_level !== 2'b01) begin
      test_fail++;
      $display("FAIL abort_setup: level got %b expected 01", sw_level);
    end
    sw_in = 2'b11;
    for (int s = 0; s < 4; s++) step();
    // ch1 sits in S_WAIT_H with cnt=2; reset lands mid-cycle, away from any edge.
    #3;
    NRST = 1'b0;
    #1;
    test_run++;
    if ({sw_level, sw_rise, sw_fall, sw_toggle} !== 8'h00) begin
      test_fail++;
      $display("FAIL abort_async_clear: got %b expected 00000000",
               {sw_level, sw_rise, sw_fall, sw_toggle});
    end
    sw_in = 2'b10;
    step();
    step();
    test_run++;
    if ({sw_level, sw_rise, sw_fall, sw_toggle} !== 8'h00) begin
      test_fail++;
      $display("FAIL abort_hold: got %b expected 00000000",
               {sw_level, sw_rise, sw_fall, sw_toggle});
    end
    NRST = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step();
      exp_lvl  = (s >= 7) ? 2'b10 : 2'b00;
      exp_rise = (s == 7) ? 2'b10 : 2'b00;
      test_run++;
      if ({sw_level, sw_rise} !== {exp_lvl, exp_rise}) begin
        test_fail++;
        $display("FAIL abort_restart step %0d: level/rise got %b expected %b",
                 s, {sw_level, sw_rise}, {exp_lvl, exp_rise});
      end
    end
  endtask

  initial begin
    NRST  = 1'b0;
    sw_in = 2'b00;
    test_reset();
    test_rise_ch0();
    test_glitch();
    test_bounce();
    test_press_release();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", test_run, test_fail);
    $finish;
  end

endmodule
